// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: sends {1'b1, addr[6:0], data[7:0]} MSB first.
// Define SPI_CONTROLLER_PENDING_EN to add a one-entry pending request buffer.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [4:0] BITS     = 5'd16;

    state_t      state_q, state_d;
    logic [8:0]  div_q, div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        ncs_q, ncs_d;
    logic        done_q, done_d;
    logic        accept;

    // Bit 15 of the frame is always the write flag, so only the low 15 bits are stored.
    logic [14:0] frame_q, frame_d;

`ifdef SPI_CONTROLLER_PENDING_EN
    logic        pend_vld_q, pend_vld_d;
    logic [14:0] pend_frame_q, pend_frame_d;

    assign ready = ~pend_vld_q;
`else
    assign ready = (state_q == IDLE);
`endif

    assign busy   = (state_q != IDLE);
    assign accept = start & ready;
    assign sclk   = sclk_q;
    assign copi   = copi_q;
    assign ncs    = ncs_q;
    assign done   = done_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ncs_d     = ncs_q;
        done_d    = 1'b0;
`ifdef SPI_CONTROLLER_PENDING_EN
        pend_vld_d   = pend_vld_q;
        pend_frame_d = pend_frame_q;
        if (accept && state_q != IDLE) begin
            pend_vld_d   = 1'b1;
            pend_frame_d = {addr, data};
        end
`endif

        case (state_q)
            IDLE: begin
                ncs_d     = 1'b1;
                sclk_d    = 1'b0;
                copi_d    = 1'b0;
                div_d     = '0;
                bit_cnt_d = '0;
                if (accept) begin
                    frame_d = {addr, data};
                    ncs_d   = 1'b0;
                    copi_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 9'd1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // The counter guard keeps a frame to at most 16 rising edges.
                        sclk_d = (bit_cnt_q != BITS);
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = (bit_cnt_q == BITS) ? BITS : bit_cnt_q + 5'd1;
                        if (bit_cnt_q >= 5'd15) begin
                            state_d = HOLD;
                        end else begin
                            copi_d  = frame_q[14];
                            frame_d = {frame_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 9'd1;
                end
            end

            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    ncs_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    div_d = div_q + 9'd1;
                end
            end

            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SPI_CONTROLLER_PENDING_EN
                    // Back-to-back frame: ncs has been high for exactly the GAP time.
                    if (pend_vld_q) begin
                        frame_d    = pend_frame_q;
                        pend_vld_d = 1'b0;
                        ncs_d      = 1'b0;
                        copi_d     = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = SETUP;
                    end
`endif
                end else begin
                    div_d = div_q + 9'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
            done_q    <= done_d;
        end
    end

`ifdef SPI_CONTROLLER_PENDING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_frame_q <= pend_frame_d;
    end
`endif

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

endmodule
